sfp_frame_tx: RTL

SFP_FRAME_TX -- requirements
Module: sfp_frame_tx

---
 rtl/sfp_frame_tx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sfp_frame_tx.sv
// sfp_frame_tx: serialises a wide parallel payload into a 32-bit AXI-Stream frame.
//
// Frame layout (NW = FRAME_BITS/32 payload words, NW+2 beats in total):
//   beat 0      : {SOF_MARKER, seq}   seq counts started frames, 0 after reset
//   beat 1..NW  : payload words, lowest 32 bits first
//   beat NW+1   : checksum = sum of payload words mod 2^32, with tlast
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-low reset
//   i_en                  transmitter enable (only gates acceptance of a start)
//   i_sfp_tx_data         parallel payload, captured when a start is accepted
//   i_sfp_tx_start_flag   single-cycle frame request
//   m_axis_*              32-bit stream master (tdata/tvalid/tready/tlast)
//   o_tx_end_flag         one-cycle pulse after the checksum beat transfers
//   o_busy                high while a frame is in progress
//   o_drop_cnt            saturating count of starts rejected while busy
//   o_state               IDLE=0, HEADER=1, PAYLOAD=2, CHECKSUM=3
module sfp_frame_tx #(
  parameter int unsigned FRAME_BITS = 1216,
  parameter logic [15:0] SOF_MARKER = 16'h5AA5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [FRAME_BITS-1:0] i_sfp_tx_data,
  input  logic                  i_sfp_tx_start_flag,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  o_tx_end_flag,
  output logic                  o_busy,
  output logic [15:0]           o_drop_cnt,
  output logic [1:0]            o_state
);

  localparam int unsigned NumWords = FRAME_BITS / 32;
  localparam int unsigned IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StHeader   = 2'd1,
    StPayload  = 2'd2,
    StChecksum = 2'd3
  } state_e;

  state_e                state_q;
  logic [FRAME_BITS-1:0] snap_q;
  logic [FRAME_BITS-1:0] snap_shift;
  logic [15:0]           seq_q;
  logic [31:0]           csum_q;
  logic [31:0]           csum_sum;
  logic [IdxW-1:0]       idx_q;
  logic [31:0]           tdata_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  end_q;
  logic [15:0]           drop_q;
  logic                  xfer;

  // The snapshot is consumed by shifting, so the next payload word is always at [31:0].
  assign snap_shift = snap_q >> 32;
  assign csum_sum   = csum_q + tdata_q;
  assign xfer       = tvalid_q & m_axis_tready;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= StIdle;
      snap_q   <= '0;
      seq_q    <= '0;
      csum_q   <= '0;
      idx_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      end_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      end_q <= 1'b0;

      // Starts while a frame is in flight are rejected regardless of i_en.
      if (i_sfp_tx_start_flag && (state_q != StIdle) && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end

      case (state_q)
        StIdle: begin
          if (i_en && i_sfp_tx_start_flag) begin
            snap_q   <= i_sfp_tx_data;
            csum_q   <= '0;
            idx_q    <= '0;
            tdata_q  <= {SOF_MARKER, seq_q};
            seq_q    <= seq_q + 16'd1;
            tvalid_q <= 1'b1;
            state_q  <= StHeader;
          end
        end
        StHeader: begin
          if (xfer) begin
            tdata_q <= snap_q[31:0];
            state_q <= StPayload;
          end
        end
        StPayload: begin
          if (xfer) begin
            csum_q <= csum_sum;
            snap_q <= snap_shift;
            if (idx_q == LastIdx) begin
              tdata_q <= csum_sum;
              tlast_q <= 1'b1;
              state_q <= StChecksum;
            end else begin
              tdata_q <= snap_shift[31:0];
              idx_q   <= idx_q + 1'b1;
            end
          end
        end
        StChecksum: begin
          if (xfer) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            end_q    <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign o_tx_end_flag = end_q;
  assign o_busy        = (state_q != StIdle);
  assign o_drop_cnt    = drop_q;
  assign o_state       = state_q;

endmodule
